// File: rtl/nv_nvdla_pdp_wdma_pack_if.sv
// Data-path bundle between the PDP core output stream, the packer and the write-DMA.
// The packer is the slave; the environment (core feed plus DMA sink) is the master.
interface nv_nvdla_pdp_wdma_pack_if #(
    parameter int unsigned DW         = 8,
    parameter int unsigned ATOM_ELEMS = 8
);
    logic [DW-1:0]            dp2wdma_pd;
    logic                     dp2wdma_valid;
    logic                     dp2wdma_ready;
    logic [DW*ATOM_ELEMS-1:0] atom_pd;
    logic [ATOM_ELEMS-1:0]    atom_mask;
    logic                     atom_line_end;
    logic                     atom_surf_end;
    logic                     atom_cube_end;
    logic                     atom_valid;
    logic                     atom_ready;
    logic                     pack_done;

    modport master (
        output dp2wdma_pd, dp2wdma_valid, atom_ready,
        input  dp2wdma_ready, atom_pd, atom_mask, atom_line_end, atom_surf_end,
        input  atom_cube_end, atom_valid, pack_done
    );

    modport slave (
        input  dp2wdma_pd, dp2wdma_valid, atom_ready,
        output dp2wdma_ready, atom_pd, atom_mask, atom_line_end, atom_surf_end,
        output atom_cube_end, atom_valid, pack_done
    );
endinterface

// File: rtl/nv_nvdla_pdp_wdma_pack.sv
// Packs the single-element PDP output stream into ATOM_ELEMS-wide atoms for the write-DMA,
// zero-padding the partial last surface and tagging line/surface/cube ends.
module nv_nvdla_pdp_wdma_pack #(
    parameter int unsigned DW         = 8,
    parameter int unsigned ATOM_ELEMS = 8
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic                    op_load,
    input  logic [12:0]             cfg_channel,
    input  logic [12:0]             cfg_width,
    input  logic [12:0]             cfg_height,
    nv_nvdla_pdp_wdma_pack_if.slave wdma
);
    localparam int unsigned AW = (ATOM_ELEMS > 1) ? $clog2(ATOM_ELEMS) : 1;
    localparam int unsigned BW = DW * ATOM_ELEMS;

    logic [AW-1:0]         elem_cnt;
    logic [12:0]           w_cnt;
    logic [12:0]           h_cnt;
    logic [9:0]            surf_cnt;
    logic [BW-1:0]         buf_pd;
    logic [BW-1:0]         buf_pd_nxt;
    logic [ATOM_ELEMS-1:0] buf_mask;
    logic [ATOM_ELEMS-1:0] buf_mask_nxt;

    logic [BW-1:0]         out_pd;
    logic [ATOM_ELEMS-1:0] out_mask;
    logic                  out_line_end;
    logic                  out_surf_end;
    logic                  out_cube_end;
    logic                  out_valid;
    logic                  done;

    logic          on_last_surf;
    logic [AW-1:0] elem_last;
    logic          pixel_last;
    logic          in_ready;
    logic          in_hs;
    logic          atom_load;
    logic          line_end;
    logic          surf_end;
    logic          cube_end;

    // The last surface carries only (cfg_channel mod ATOM_ELEMS)+1 real channels.
    assign on_last_surf = ({3'b0, surf_cnt} == (cfg_channel >> AW));
    assign elem_last    = on_last_surf ? cfg_channel[AW-1:0] : {AW{1'b1}};
    assign pixel_last   = (elem_cnt == elem_last);

    // Only the completing element needs the output register to be free (or draining).
    assign in_ready  = ~(pixel_last & out_valid & ~wdma.atom_ready);
    assign in_hs     = wdma.dp2wdma_valid & in_ready & ~op_load;
    assign atom_load = in_hs & pixel_last;

    assign line_end = (w_cnt == cfg_width);
    assign surf_end = line_end & (h_cnt == cfg_height);
    assign cube_end = surf_end & on_last_surf;

    always_comb begin
        buf_pd_nxt   = buf_pd;
        buf_mask_nxt = buf_mask;
        for (int k = 0; k < ATOM_ELEMS; k++) begin
            if (elem_cnt == AW'(k)) begin
                buf_pd_nxt[k*DW +: DW] = wdma.dp2wdma_pd;
                buf_mask_nxt[k]        = 1'b1;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            elem_cnt <= '0;
            w_cnt    <= '0;
            h_cnt    <= '0;
            surf_cnt <= '0;
            buf_pd   <= '0;
            buf_mask <= '0;
        end else if (op_load) begin
            elem_cnt <= '0;
            w_cnt    <= '0;
            h_cnt    <= '0;
            surf_cnt <= '0;
            buf_pd   <= '0;
            buf_mask <= '0;
        end else if (in_hs) begin
            if (pixel_last) begin
                elem_cnt <= '0;
                buf_pd   <= '0;
                buf_mask <= '0;
                if (cube_end) begin
                    w_cnt    <= '0;
                    h_cnt    <= '0;
                    surf_cnt <= '0;
                end else if (surf_end) begin
                    w_cnt    <= '0;
                    h_cnt    <= '0;
                    surf_cnt <= surf_cnt + 10'd1;
                end else if (line_end) begin
                    w_cnt <= '0;
                    h_cnt <= h_cnt + 13'd1;
                end else begin
                    w_cnt <= w_cnt + 13'd1;
                end
            end else begin
                elem_cnt <= elem_cnt + AW'(1);
                buf_pd   <= buf_pd_nxt;
                buf_mask <= buf_mask_nxt;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            out_pd       <= '0;
            out_mask     <= '0;
            out_line_end <= 1'b0;
            out_surf_end <= 1'b0;
            out_cube_end <= 1'b0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (atom_load) begin
                out_pd       <= buf_pd_nxt;
                out_mask     <= buf_mask_nxt;
                out_line_end <= line_end;
                out_surf_end <= surf_end;
                out_cube_end <= cube_end;
                out_valid    <= 1'b1;
            end else if (wdma.atom_ready) begin
                out_valid <= 1'b0;
            end
            done <= out_valid & wdma.atom_ready & out_cube_end;
        end
    end

    assign wdma.dp2wdma_ready = in_ready;
    assign wdma.atom_pd       = out_pd;
    assign wdma.atom_mask     = out_mask;
    assign wdma.atom_line_end = out_line_end;
    assign wdma.atom_surf_end = out_surf_end;
    assign wdma.atom_cube_end = out_cube_end;
    assign wdma.atom_valid    = out_valid;
    assign wdma.pack_done     = done;
endmodule

// File: tb/tb_nv_nvdla_pdp_wdma_pack.sv
// Directed bench for the PDP write-DMA packer: full and partial surfaces, backpressure,
// drain/load overlap, line/surface wrap, asynchronous reset and op_load.
module tb_nv_nvdla_pdp_wdma_pack;
    logic        clk;
    logic        rstn;
    logic        op_load;
    logic [12:0] cfg_channel;
    logic [12:0] cfg_width;
    logic [12:0] cfg_height;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [63:0] pd;
        logic [7:0]  mask;
        logic [2:0]  fl;
        logic [31:0] hs;
    } atom_t;

    atom_t       q[$];
    logic [31:0] cyc;
    int          done_cnt;
    logic [31:0] done_cyc;

    nv_nvdla_pdp_wdma_pack_if #(.DW(8), .ATOM_ELEMS(8)) wdma ();

    nv_nvdla_pdp_wdma_pack #(.DW(8), .ATOM_ELEMS(8)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .op_load         (op_load),
        .cfg_channel     (cfg_channel),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .wdma            (wdma.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Record each atom on the cycle it will handshake; hs is the index of that edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (wdma.atom_valid && wdma.atom_ready)
                q.push_back('{pd: wdma.atom_pd, mask: wdma.atom_mask,
                              fl: {wdma.atom_line_end, wdma.atom_surf_end, wdma.atom_cube_end},
                              hs: cyc + 32'd1});
            if (wdma.pack_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [12:0] ch, input logic [12:0] w, input logic [12:0] h);
        cfg_channel = ch;
        cfg_width   = w;
        cfg_height  = h;
        op_load     = 1'b1;
        @(posedge clk);
        #1;
        op_load = 1'b0;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that took the element.
    task automatic send(input logic [7:0] d, output int waits);
        wdma.dp2wdma_pd    = d;
        wdma.dp2wdma_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!wdma.dp2wdma_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 100) begin
            miscompares++;
            $error("FAIL send_timeout: observed stalled expected accepted");
        end
        @(posedge clk);
        #1;
        wdma.dp2wdma_valid = 1'b0;
    endtask

    task automatic wait_atoms(input int base, input int n);
        int t;
        t = 0;
        while (q.size() < base + n && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (t > 0) #1;
        chk("atom_count", 64'(q.size() - base), 64'(n));
    endtask

    initial begin
        int          w;
        int          b;
        int          d0;
        logic [63:0] e;
        logic [63:0] held;
        logic        stable;

        vectors            = 0;
        miscompares        = 0;
        cyc                = 0;
        done_cnt           = 0;
        done_cyc           = 0;
        rstn               = 1'b0;
        op_load            = 1'b0;
        cfg_channel        = '0;
        cfg_width          = '0;
        cfg_height         = '0;
        wdma.dp2wdma_pd    = '0;
        wdma.dp2wdma_valid = 1'b0;
        wdma.atom_ready    = 1'b0;

        // Reset state
        #3;
        chk("rst_atom_valid", 64'(wdma.atom_valid), 64'd0);
        chk("rst_atom_pd", wdma.atom_pd, 64'd0);
        chk("rst_atom_mask", 64'(wdma.atom_mask), 64'd0);
        chk("rst_flags", 64'({wdma.atom_line_end, wdma.atom_surf_end, wdma.atom_cube_end}), 64'd0);
        chk("rst_pack_done", 64'(wdma.pack_done), 64'd0);
        chk("rst_in_ready", 64'(wdma.dp2wdma_ready), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Full surface, two pixels
        wdma.atom_ready = 1'b1;
        do_load(13'd7, 13'd1, 13'd0);
        b  = q.size();
        d0 = done_cnt;
        for (int i = 1; i <= 16; i++) send(8'(i), w);
        wait_atoms(b, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_a0_pd", q[b].pd, 64'h0807060504030201);
        chk("t1_a0_mask", 64'(q[b].mask), 64'hFF);
        chk("t1_a0_flags", 64'(q[b].fl), 64'b000);
        chk("t1_a1_pd", q[b+1].pd, 64'h100F0E0D0C0B0A09);
        chk("t1_a1_mask", 64'(q[b+1].mask), 64'hFF);
        chk("t1_a1_flags", 64'(q[b+1].fl), 64'b111);
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t1_done_cyc", 64'(done_cyc), 64'(q[b+1].hs));

        // Partial last surface
        do_load(13'd10, 13'd0, 13'd0);
        b = q.size();
        for (int i = 0; i <= 10; i++) send(8'(8'hA0 + i), w);
        wait_atoms(b, 2);
        chk("t2_a0_pd", q[b].pd, 64'hA7A6A5A4A3A2A1A0);
        chk("t2_a0_mask", 64'(q[b].mask), 64'hFF);
        chk("t2_a0_flags", 64'(q[b].fl), 64'b110);
        chk("t2_a1_pd", q[b+1].pd, 64'h0000000000AAA9A8);
        chk("t2_a1_mask", 64'(q[b+1].mask), 64'h07);
        chk("t2_a1_flags", 64'(q[b+1].fl), 64'b111);

        // Backpressure: atom0 held while the next pixel fills
        wdma.atom_ready = 1'b0;
        do_load(13'd7, 13'd3, 13'd0);
        b = q.size();
        for (int i = 1; i <= 8; i++) send(8'(i), w);
        for (int i = 9; i <= 15; i++) begin
            send(8'(i), w);
            chk($sformatf("t3_e%0d_waits", i - 1), 64'(w), 64'd0);
        end
        wdma.dp2wdma_pd    = 8'd16;
        wdma.dp2wdma_valid = 1'b1;
        @(negedge clk);
        chk("t3_e15_ready", 64'(wdma.dp2wdma_ready), 64'd0);
        held   = wdma.atom_pd;
        stable = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (wdma.atom_pd !== held || wdma.atom_valid !== 1'b1 || wdma.dp2wdma_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("t3_hold_stable", 64'(stable), 64'd1);
        chk("t3_held_pd", held, 64'h0807060504030201);
        @(posedge clk);
        #1;
        wdma.atom_ready = 1'b1;
        @(negedge clk);
        chk("t3_e15_release", 64'(wdma.dp2wdma_ready), 64'd1);
        @(posedge clk);
        #1;
        wdma.dp2wdma_valid = 1'b0;
        for (int i = 17; i <= 32; i++) send(8'(i), w);
        wait_atoms(b, 4);
        chk("t3_a0_pd", q[b].pd, 64'h0807060504030201);
        chk("t3_a1_pd", q[b+1].pd, 64'h100F0E0D0C0B0A09);
        chk("t3_a2_pd", q[b+2].pd, 64'h1817161514131211);
        chk("t3_a3_pd", q[b+3].pd, 64'h201F1E1D1C1B1A19);
        chk("t3_a3_flags", 64'(q[b+3].fl), 64'b111);

        // Drain and load on the same edge
        wdma.atom_ready = 1'b0;
        do_load(13'd7, 13'd1, 13'd0);
        b  = q.size();
        d0 = done_cnt;
        for (int i = 0; i < 15; i++) send(8'(8'h21 + i), w);
        wdma.dp2wdma_pd    = 8'h30;
        wdma.dp2wdma_valid = 1'b1;
        wdma.atom_ready    = 1'b1;
        @(negedge clk);
        chk("t4_in_ready", 64'(wdma.dp2wdma_ready), 64'd1);
        @(posedge clk);
        #1;
        wdma.dp2wdma_valid = 1'b0;
        chk("t4_valid_no_bubble", 64'(wdma.atom_valid), 64'd1);
        chk("t4_a1_pd", wdma.atom_pd, 64'h302F2E2D2C2B2A29);
        chk("t4_a1_cube", 64'(wdma.atom_cube_end), 64'd1);
        chk("t4_a0_count", 64'(q.size() - b), 64'd1);
        chk("t4_a0_pd", q[b].pd, 64'h2827262524232221);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Line/surface wrap across two surfaces of 2x2 pixels
        do_load(13'd15, 13'd1, 13'd1);
        b = q.size();
        for (int j = 0; j < 64; j++) send(8'(j), w);
        wait_atoms(b, 8);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) e[k*8 +: 8] = 8'(8 * i + k);
            chk($sformatf("t5_a%0d_pd", i), q[b+i].pd, e);
            chk($sformatf("t5_a%0d_flags", i), 64'(q[b+i].fl),
                64'({(i % 2) == 1, (i == 3) || (i == 7), i == 7}));
        end

        // Asynchronous reset mid-pixel with an atom pending, then op_load
        wdma.atom_ready = 1'b0;
        do_load(13'd7, 13'd1, 13'd0);
        for (int i = 0; i < 11; i++) send(8'(8'h51 + i), w);
        chk("t6_pending_valid", 64'(wdma.atom_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(wdma.atom_valid), 64'd0);
        chk("t6_rst_pd", wdma.atom_pd, 64'd0);
        chk("t6_rst_mask", 64'(wdma.atom_mask), 64'd0);
        chk("t6_rst_flags",
            64'({wdma.atom_line_end, wdma.atom_surf_end, wdma.atom_cube_end, wdma.pack_done}),
            64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        b = q.size();
        wdma.atom_ready = 1'b1;
        do_load(13'd7, 13'd0, 13'd0);
        for (int i = 0; i < 8; i++) send(8'(8'hB0 + i), w);
        wait_atoms(b, 1);
        chk("t6_fresh_pd", q[b].pd, 64'hB7B6B5B4B3B2B1B0);
        chk("t6_fresh_mask", 64'(q[b].mask), 64'hFF);
        chk("t6_fresh_flags", 64'(q[b].fl), 64'b111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
